vec_mem_arbiter: RTL and testbench
==================================

Name: vec_mem_arbiter

Overview:
- Shares the single main-memory port between the scalar core's load/store path and the vector LSU element stream.
- Round-robin arbitration when the port is free.
- A vector lock holds the port for a whole strided/unit-stride element sequence; a bounded-burst yield rule prevents scalar starvation.
- Tracks outstanding requests in order and routes each memory response back to the requester that issued it.

Parameters:
- XLEN, 32, address and data width for the scalar side and memory. SEW must equal XLEN.
- SEW, 32, vector element width on the LSU side.
- MAX_OUTST, 4, depth of the outstanding-request ID FIFO (power of 2).
- BURST_LIMIT, 16, number of locked vector transfers before a waiting scalar request gets one slot.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- sc_req_valid  in  1  scalar request valid
- sc_req_ready  out  1  scalar request accepted this cycle
- sc_addr  in  XLEN  scalar byte address
- sc_we  in  1  1=store, 0=load
- sc_wdata  in  XLEN  scalar store data
- sc_rsp_valid  out  1  scalar response (load data or store ack)
- sc_rsp_data  out  XLEN  scalar load data
- vl_req_valid  in  1  vector LSU element request valid
- vl_req_ready  out  1  vector request accepted
- vl_addr  in  XLEN  element address
- vl_we  in  1  1=store, 0=load
- vl_wdata  in  SEW  element store data
- vl_lock  in  1  hold port for vector sequence
- vl_rsp_valid  out  1  vector response
- vl_rsp_data  out  SEW  element load data
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  XLEN  muxed address
- mem_we  out  1  muxed write enable
- mem_wdata  out  XLEN  muxed write data
- mem_rsp_valid  in  1  in-order response, one per accepted request (loads and stores)
- mem_rsp_data  in  XLEN  response data
- busy  out  1  outstanding requests exist or state != ARB

Behaviour:
- Handshake: a transfer occurs when valid && ready. Requesters hold valid and payload stable until accepted.
- Request path is combinational. The grant is computed from registered state and current valids. mem_req_valid = valid of granted requester && !fifo_full. Granted ready = mem_req_ready && !fifo_full. The non-granted ready = 0. mem_addr/we/wdata come from the granted requester (vector when none is granted).
- fifo_full blocks acceptance even if a response pops the FIFO in the same cycle.
- States:
  - ARB: both valid → grant the requester not granted last (last_grant reg, reset = VECTOR so scalar wins the first tie). Otherwise grant whichever is valid.
  - VLOCK: only the vector is granted; it counts vector transfers in burst_cnt.
  - YIELD: only the scalar is granted.
- Transitions:
  - ARB→VLOCK at a vector transfer with vl_lock=1; burst_cnt cleared to 0 (the locking transfer is not counted).
  - VLOCK→ARB at the end of any cycle with vl_lock=0. Takes priority over yield.
  - VLOCK→YIELD when burst_cnt == BURST_LIMIT && sc_req_valid, evaluated at end of cycle. If scalar is not waiting, burst_cnt saturates at BURST_LIMIT.
  - YIELD→VLOCK at the scalar transfer; burst_cnt cleared. If vl_lock=0 at that point, go to ARB instead.
- last_grant updates on every transfer.
- ID FIFO: push the requester ID on every transfer. Pop on mem_rsp_valid; the head ID selects sc_rsp_valid or vl_rsp_valid. Response data is passed combinationally to both rsp_data outputs.
- mem_rsp_valid with an empty FIFO is dropped: no rsp pulse, FIFO unchanged.
- Simultaneous push and pop: both happen, and the count is unchanged.
- Reset values: state=ARB, FIFO empty, burst_cnt=0, last_grant=VECTOR. All ready/valid outputs are 0 while n_rst=0, and busy=0.
- Reset mid-operation: outstanding IDs are discarded; responses arriving after reset are dropped per the empty-FIFO rule.

Test Plan:
1. Both requesters valid every cycle, vl_lock=0, mem_req_ready=1, 1-cycle response → grants alternate S,V,S,V; each rsp is routed to its issuer with matching data.
2. Vector asserts vl_lock with 8 elements at 0x1000 stride 4, scalar idle → 8 consecutive vector transfers with addresses 0x1000..0x101C. State returns to ARB the cycle after vl_lock drops.
3. vl_lock held, BURST_LIMIT=16, scalar valid from cycle 0 → 1 locking transfer + 16 vector transfers, then exactly one scalar transfer, then vector resumes; no scalar starvation.
4. mem_rsp_valid held low, 4 requests accepted → the 5th request sees ready=0 and busy=1. One response pops the FIFO; acceptance resumes the following cycle.
5. mem_rsp_valid pulse with FIFO empty → no sc_rsp_valid/vl_rsp_valid pulse, busy stays 0.
6. n_rst asserted with 3 outstanding requests during VLOCK → immediately state=ARB, busy=0, readies=0. Late responses after release produce no rsp pulses.

Source files
------------

// File: rtl/vec_mem_arbiter.sv
// Arbitrates the single main-memory port between the scalar load/store path and the vector LSU,
// with vector locking, bounded-burst scalar yield and in-order response routing.
module vec_mem_arbiter #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned SEW         = 32,
  parameter int unsigned MAX_OUTST   = 4,
  parameter int unsigned BURST_LIMIT = 16
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            sc_req_valid,
  output logic            sc_req_ready,
  input  logic [XLEN-1:0] sc_addr,
  input  logic            sc_we,
  input  logic [XLEN-1:0] sc_wdata,
  output logic            sc_rsp_valid,
  output logic [XLEN-1:0] sc_rsp_data,
  input  logic            vl_req_valid,
  output logic            vl_req_ready,
  input  logic [XLEN-1:0] vl_addr,
  input  logic            vl_we,
  input  logic [SEW-1:0]  vl_wdata,
  input  logic            vl_lock,
  output logic            vl_rsp_valid,
  output logic [SEW-1:0]  vl_rsp_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            busy
);

  localparam logic [1:0] StArb   = 2'd0;
  localparam logic [1:0] StVlock = 2'd1;
  localparam logic [1:0] StYield = 2'd2;

  localparam logic IdScalar = 1'b0;

  localparam int unsigned CntW   = $clog2(BURST_LIMIT + 1);
  localparam int unsigned PtrW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CountW = $clog2(MAX_OUTST + 1);

  localparam logic [CntW-1:0]   BurstMax = CntW'(BURST_LIMIT);
  localparam logic [CountW-1:0] FullCnt  = CountW'(MAX_OUTST);

  logic [1:0]        state_q, state_d;
  logic              last_vec_q, last_vec_d;
  logic [CntW-1:0]   burst_cnt_q, burst_cnt_d, burst_cnt_inc;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q, count_d;
  logic              ids_q [MAX_OUTST];

  logic gnt_sc, gnt_vl;
  logic fifo_full, fifo_empty, accept;
  logic sc_xfer, vl_xfer, push, pop, head_id;

  // Grant depends on registered state and the live valids only.
  always_comb begin
    gnt_sc = 1'b0;
    gnt_vl = 1'b0;
    unique case (state_q)
      StVlock: gnt_vl = vl_req_valid;
      StYield: gnt_sc = sc_req_valid;
      default: begin
        if (sc_req_valid && vl_req_valid) begin
          gnt_sc = last_vec_q;
          gnt_vl = !last_vec_q;
        end else begin
          gnt_sc = sc_req_valid;
          gnt_vl = vl_req_valid;
        end
      end
    endcase
  end

  assign fifo_full  = (count_q == FullCnt);
  assign fifo_empty = (count_q == '0);
  // A same-cycle pop does not free a slot for acceptance.
  assign accept     = mem_req_ready && !fifo_full && n_rst;

  assign sc_req_ready  = gnt_sc && accept;
  assign vl_req_ready  = gnt_vl && accept;
  assign mem_req_valid = (gnt_sc || gnt_vl) && !fifo_full && n_rst;
  assign sc_xfer       = sc_req_ready;
  assign vl_xfer       = vl_req_ready;

  assign mem_addr  = gnt_sc ? sc_addr  : vl_addr;
  assign mem_we    = gnt_sc ? sc_we    : vl_we;
  assign mem_wdata = gnt_sc ? sc_wdata : XLEN'(vl_wdata);

  assign push    = sc_xfer || vl_xfer;
  assign pop     = mem_rsp_valid && !fifo_empty && n_rst;
  assign head_id = ids_q[rd_ptr_q];

  assign sc_rsp_valid = pop && (head_id == IdScalar);
  assign vl_rsp_valid = pop && (head_id != IdScalar);
  assign sc_rsp_data  = mem_rsp_data;
  assign vl_rsp_data  = SEW'(mem_rsp_data);

  assign busy = n_rst && ((count_q != '0) || (state_q != StArb));

  assign burst_cnt_inc = (vl_xfer && (burst_cnt_q != BurstMax)) ? burst_cnt_q + 1'b1
                                                                : burst_cnt_q;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_vec_d  = last_vec_q;
    if (push) last_vec_d = vl_xfer;
    unique case (state_q)
      StArb: begin
        if (vl_xfer && vl_lock) begin
          state_d     = StVlock;
          burst_cnt_d = '0;
        end
      end
      StVlock: begin
        burst_cnt_d = burst_cnt_inc;
        // Lock release wins over a pending yield.
        if (!vl_lock) begin
          state_d = StArb;
        end else if ((burst_cnt_inc == BurstMax) && sc_req_valid) begin
          state_d = StYield;
        end
      end
      StYield: begin
        if (sc_xfer) begin
          burst_cnt_d = '0;
          state_d     = vl_lock ? StVlock : StArb;
        end
      end
      default: state_d = StArb;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StArb;
      last_vec_q  <= 1'b1;
      burst_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_vec_q  <= last_vec_d;
      burst_cnt_q <= burst_cnt_d;
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ID storage needs no reset; the count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) ids_q[wr_ptr_q] <= vl_xfer;
  end

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Self-checking bench for vec_mem_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_vec_mem_arbiter;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned SEW         = 32;
  localparam int unsigned MAX_OUTST   = 4;
  localparam int unsigned BURST_LIMIT = 16;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            sc_req_valid, sc_req_ready, sc_we, sc_rsp_valid;
  logic [XLEN-1:0] sc_addr, sc_wdata, sc_rsp_data;
  logic            vl_req_valid, vl_req_ready, vl_we, vl_lock, vl_rsp_valid;
  logic [XLEN-1:0] vl_addr;
  logic [SEW-1:0]  vl_wdata, vl_rsp_data;
  logic            mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid, busy;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rsp_data;

  int checks = 0;
  int errors = 0;

  // Reference model: mode flags, vector-transfer tally, issuer queue.
  bit m_lock, m_yield, m_last_vec;
  int m_cnt;
  bit m_q[$];

  always #5 clk = ~clk;

  vec_mem_arbiter #(
    .XLEN(XLEN), .SEW(SEW), .MAX_OUTST(MAX_OUTST), .BURST_LIMIT(BURST_LIMIT)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .sc_req_valid(sc_req_valid), .sc_req_ready(sc_req_ready), .sc_addr(sc_addr),
    .sc_we(sc_we), .sc_wdata(sc_wdata), .sc_rsp_valid(sc_rsp_valid), .sc_rsp_data(sc_rsp_data),
    .vl_req_valid(vl_req_valid), .vl_req_ready(vl_req_ready), .vl_addr(vl_addr),
    .vl_we(vl_we), .vl_wdata(vl_wdata), .vl_lock(vl_lock), .vl_rsp_valid(vl_rsp_valid),
    .vl_rsp_data(vl_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  // 0 = nobody, 1 = scalar, 2 = vector
  function automatic int m_grant(input bit sv, input bit vv);
    if (m_yield) return sv ? 1 : 0;
    if (m_lock) return vv ? 2 : 0;
    if (sv && vv) return m_last_vec ? 1 : 2;
    if (sv) return 1;
    if (vv) return 2;
    return 0;
  endfunction

  function automatic void m_update(input bit sv, input bit vv, input bit lock, input bit rdy,
                                   input bit rspv, output bit xs, output bit xv);
    int g;
    bit full;
    g    = m_grant(sv, vv);
    full = (m_q.size() >= MAX_OUTST);
    xs   = (g == 1) && rdy && !full;
    xv   = (g == 2) && rdy && !full;
    if (rspv && m_q.size() > 0) void'(m_q.pop_front());
    if (xs || xv) begin
      m_q.push_back(xv);
      m_last_vec = xv;
    end
    if (m_yield) begin
      if (xs) begin
        m_yield = 1'b0;
        m_lock  = lock;
        m_cnt   = 0;
      end
    end else if (m_lock) begin
      if (!lock) begin
        m_lock = 1'b0;
      end else begin
        if (xv && m_cnt < BURST_LIMIT) m_cnt++;
        if (m_cnt == BURST_LIMIT && sv) m_yield = 1'b1;
      end
    end else if (xv && lock) begin
      m_lock = 1'b1;
      m_cnt  = 0;
    end
  endfunction

  task automatic do_reset();
    n_rst = 1'b0;
    sc_req_valid = 0; sc_addr = '0; sc_we = 0; sc_wdata = '0;
    vl_req_valid = 0; vl_addr = '0; vl_we = 0; vl_wdata = '0; vl_lock = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    m_lock = 0; m_yield = 0; m_last_vec = 1; m_cnt = 0; m_q.delete();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    sc_req_valid = 1; vl_req_valid = 1; mem_req_ready = 1; mem_rsp_valid = 1; vl_lock = 0;
    #1;
    checks++;
    if ({sc_req_ready, vl_req_ready, mem_req_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready: got %b required 000", {sc_req_ready, vl_req_ready, mem_req_valid});
    end
    checks++;
    if ({sc_rsp_valid, vl_rsp_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_rsp_busy: got %b required 000", {sc_rsp_valid, vl_rsp_valid, busy});
    end
    do_reset();
  endtask

  task automatic test_alternate();
    int n_sc = 0;
    int n_vl = 0;
    bit prev_vec = 0;
    bit exp_sc;
    logic [XLEN-1:0] rdata, exp_addr;
    do_reset();
    sc_req_valid = 1; vl_req_valid = 1; mem_req_ready = 1; mem_rsp_valid = 1;
    for (int k = 0; k < 8; k++) begin
      sc_addr = 32'h2000 + n_sc * 4; sc_wdata = ~sc_addr; sc_we = 1;
      vl_addr = 32'h3000 + n_vl * 4; vl_wdata = ~vl_addr; vl_we = 0;
      rdata = $urandom; mem_rsp_data = rdata;
      #4;
      exp_sc   = (k % 2 == 0);
      exp_addr = exp_sc ? 32'h2000 + n_sc * 4 : 32'h3000 + n_vl * 4;
      checks++;
      if (sc_req_ready !== exp_sc || vl_req_ready !== !exp_sc) begin
        errors++;
        $display("FAIL alt_grant cycle %0d: got sc=%b vl=%b required sc=%b", k, sc_req_ready,
                 vl_req_ready, exp_sc);
      end
      checks++;
      if (mem_addr !== exp_addr || mem_we !== exp_sc || mem_wdata !== ~exp_addr) begin
        errors++;
        $display("FAIL alt_payload cycle %0d: got %h/%b required %h/%b", k, mem_addr, mem_we,
                 exp_addr, exp_sc);
      end
      checks++;
      if (k == 0) begin
        if (sc_rsp_valid !== 0 || vl_rsp_valid !== 0) begin
          errors++;
          $display("FAIL alt_first_rsp: got %b%b required 00", sc_rsp_valid, vl_rsp_valid);
        end
      end else if (sc_rsp_valid !== !prev_vec || vl_rsp_valid !== prev_vec ||
                   (prev_vec ? vl_rsp_data : sc_rsp_data) !== rdata) begin
        errors++;
        $display("FAIL alt_route cycle %0d: got sc=%b vl=%b required vec=%b data %h", k,
                 sc_rsp_valid, vl_rsp_valid, prev_vec, rdata);
      end
      if (exp_sc) n_sc++; else n_vl++;
      prev_vec = !exp_sc;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock_seq();
    do_reset();
    vl_lock = 1; vl_req_valid = 1; mem_req_ready = 1; mem_rsp_valid = 1;
    for (int i = 0; i < 8; i++) begin
      vl_addr = 32'h1000 + i * 4;
      #4;
      checks++;
      if (vl_req_ready !== 1 || mem_req_valid !== 1 || mem_addr !== 32'h1000 + i * 4) begin
        errors++;
        $display("FAIL lock_elem %0d: got rdy=%b addr=%h required 1/%h", i, vl_req_ready,
                 mem_addr, 32'h1000 + i * 4);
      end
      @(posedge clk); #1;
    end
    vl_req_valid = 0; vl_lock = 0;
    #4;
    checks++;
    if (busy !== 1) begin
      errors++;
      $display("FAIL lock_drop_busy: got %b required 1", busy);
    end
    @(posedge clk); #1;
    sc_req_valid = 1; sc_addr = 32'h80;
    #4;
    checks++;
    if (busy !== 0 || sc_req_ready !== 1) begin
      errors++;
      $display("FAIL lock_back_arb: got busy=%b sc_rdy=%b required 0/1", busy, sc_req_ready);
    end
    @(posedge clk); #1;
    sc_req_valid = 0;
  endtask

  task automatic test_yield();
    int v = 0;
    bit exp_sc;
    do_reset();
    mem_req_ready = 1; mem_rsp_valid = 1;
    sc_req_valid = 1; sc_addr = 32'h40;
    #4;
    checks++;
    if (sc_req_ready !== 1) begin
      errors++;
      $display("FAIL yield_pre: got %b required 1", sc_req_ready);
    end
    @(posedge clk); #1;
    sc_addr = 32'h44; vl_req_valid = 1; vl_lock = 1;
    for (int c = 0; c < 19; c++) begin
      vl_addr = 32'h5000 + v * 4;
      #4;
      exp_sc = (c == BURST_LIMIT + 1);
      checks++;
      if (sc_req_ready !== exp_sc || vl_req_ready !== !exp_sc) begin
        errors++;
        $display("FAIL yield_slot cycle %0d: got sc=%b vl=%b required sc=%b", c, sc_req_ready,
                 vl_req_ready, exp_sc);
      end
      if (!exp_sc) v++;
      @(posedge clk); #1;
      if (exp_sc) sc_req_valid = 0;
    end
    vl_req_valid = 0; vl_lock = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    do_reset();
    mem_req_ready = 1; mem_rsp_valid = 0; sc_req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      sc_addr = 32'h100 + i * 4;
      #4;
      checks++;
      if (sc_req_ready !== 1) begin
        errors++;
        $display("FAIL full_fill %0d: got %b required 1", i, sc_req_ready);
      end
      @(posedge clk); #1;
    end
    sc_addr = 32'h110;
    #4;
    checks++;
    if (sc_req_ready !== 0 || mem_req_valid !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL full_block: got rdy=%b mv=%b busy=%b required 0/0/1", sc_req_ready,
               mem_req_valid, busy);
    end
    @(posedge clk); #1;
    mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_0001;
    #4;
    checks++;
    if (sc_rsp_valid !== 1 || sc_rsp_data !== 32'hCAFE_0001 || sc_req_ready !== 0) begin
      errors++;
      $display("FAIL full_pop: got rsp=%b data=%h rdy=%b required 1/cafe0001/0", sc_rsp_valid,
               sc_rsp_data, sc_req_ready);
    end
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    #4;
    checks++;
    if (sc_req_ready !== 1) begin
      errors++;
      $display("FAIL full_resume: got %b required 1", sc_req_ready);
    end
    @(posedge clk); #1;
    sc_req_valid = 0; mem_rsp_valid = 1;
    repeat (5) @(posedge clk);
    #1 mem_rsp_valid = 0;
  endtask

  task automatic test_empty_rsp();
    do_reset();
    mem_rsp_valid = 1; mem_rsp_data = $urandom;
    #4;
    checks++;
    if ({sc_rsp_valid, vl_rsp_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL empty_rsp: got %b required 000", {sc_rsp_valid, vl_rsp_valid, busy});
    end
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    #4;
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL empty_rsp_after: got busy=%b required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_req_ready = 1; vl_lock = 1; vl_req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      vl_addr = 32'h6000 + i * 4;
      #4;
      checks++;
      if (vl_req_ready !== 1) begin
        errors++;
        $display("FAIL rmid_issue %0d: got %b required 1", i, vl_req_ready);
      end
      @(posedge clk); #1;
    end
    sc_req_valid = 1;
    #4;
    checks++;
    if (busy !== 1) begin
      errors++;
      $display("FAIL rmid_busy_before: got %b required 1", busy);
    end
    n_rst = 0;
    #1;
    checks++;
    if ({busy, sc_req_ready, vl_req_ready, mem_req_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_in_reset: got %b required 0000",
               {busy, sc_req_ready, vl_req_ready, mem_req_valid});
    end
    @(posedge clk); #1;
    sc_req_valid = 0; vl_req_valid = 0; vl_lock = 0; n_rst = 1;
    mem_rsp_valid = 1;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_data = $urandom;
      #4;
      checks++;
      if ({sc_rsp_valid, vl_rsp_valid, busy} !== 3'b000) begin
        errors++;
        $display("FAIL rmid_late_rsp %0d: got %b required 000", i,
                 {sc_rsp_valid, vl_rsp_valid, busy});
      end
      @(posedge clk); #1;
    end
    mem_rsp_valid = 0;
  endtask

  task automatic test_random();
    bit sc_p = 0;
    bit vl_p = 0;
    bit xs, xv, full, e_sr, e_vr, e_mv, e_srsp, e_vrsp, e_busy;
    int g;
    logic [XLEN-1:0] e_addr, e_wdata;
    bit e_we;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (!sc_p && ($urandom % 2 == 0)) begin
        sc_p = 1; sc_addr = $urandom; sc_we = 1'($urandom); sc_wdata = $urandom;
      end
      if (!vl_p && ($urandom % 4 != 0)) begin
        vl_p = 1; vl_addr = $urandom; vl_we = 1'($urandom); vl_wdata = $urandom;
      end
      sc_req_valid = sc_p; vl_req_valid = vl_p;
      if ($urandom % 40 == 0) vl_lock = !vl_lock;
      mem_req_ready = ($urandom % 4) != 0;
      mem_rsp_valid = ($urandom % 2) == 0;
      mem_rsp_data  = $urandom;
      #4;
      g       = m_grant(sc_p, vl_p);
      full    = (m_q.size() >= MAX_OUTST);
      e_sr    = (g == 1) && mem_req_ready && !full;
      e_vr    = (g == 2) && mem_req_ready && !full;
      e_mv    = (g != 0) && !full;
      e_addr  = (g == 1) ? sc_addr : vl_addr;
      e_we    = (g == 1) ? sc_we : vl_we;
      e_wdata = (g == 1) ? sc_wdata : vl_wdata;
      e_srsp  = mem_rsp_valid && m_q.size() > 0 && m_q[0] == 1'b0;
      e_vrsp  = mem_rsp_valid && m_q.size() > 0 && m_q[0] == 1'b1;
      e_busy  = (m_q.size() != 0) || m_lock || m_yield;
      checks++;
      if (sc_req_ready !== e_sr || vl_req_ready !== e_vr || mem_req_valid !== e_mv) begin
        errors++;
        $display("FAIL rand_handshake cycle %0d: got %b%b%b required %b%b%b", c, sc_req_ready,
                 vl_req_ready, mem_req_valid, e_sr, e_vr, e_mv);
      end
      if (e_mv) begin
        checks++;
        if (mem_addr !== e_addr || mem_we !== e_we || mem_wdata !== e_wdata) begin
          errors++;
          $display("FAIL rand_payload cycle %0d: got %h/%b/%h required %h/%b/%h", c, mem_addr,
                   mem_we, mem_wdata, e_addr, e_we, e_wdata);
        end
      end
      checks++;
      if (sc_rsp_valid !== e_srsp || vl_rsp_valid !== e_vrsp || busy !== e_busy) begin
        errors++;
        $display("FAIL rand_rsp cycle %0d: got sc=%b vl=%b busy=%b required %b %b %b", c,
                 sc_rsp_valid, vl_rsp_valid, busy, e_srsp, e_vrsp, e_busy);
      end
      if (e_srsp || e_vrsp) begin
        checks++;
        if ((e_srsp ? sc_rsp_data : vl_rsp_data) !== mem_rsp_data) begin
          errors++;
          $display("FAIL rand_rsp_data cycle %0d: got %h required %h", c,
                   e_srsp ? sc_rsp_data : vl_rsp_data, mem_rsp_data);
        end
      end
      m_update(sc_p, vl_p, vl_lock, mem_req_ready, mem_rsp_valid, xs, xv);
      if (xs) sc_p = 0;
      if (xv) vl_p = 0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_lock_seq();
    test_yield();
    test_full();
    test_empty_rsp();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
